// File: rtl/nexys_starship_lanes.sv
// Multi-lane monster manager: global INIT/PLAY/OVER control over LANES spawn/occupancy lanes with a saturating kill score.
// Optional NEXYS_SS_ONE_SPAWN_EN limits spawning to the lowest-index eligible lane per edge.
module nexys_starship_lanes #(
  parameter int LANES       = 4,
  parameter int TIMER_W     = 8,
  parameter int SPAWN_DELAY = 2,
  parameter int TIMEOUT     = 6,
  parameter int SCORE_W     = 8
) (
  input  logic               timer_clk,
  input  logic               Reset,
  input  logic               play_flag,
  input  logic [LANES-1:0]   random,
  input  logic [LANES-1:0]   kill,
  output logic [LANES-1:0]   monster,
  output logic               gameover,
  output logic [SCORE_W-1:0] score,
  output logic               q_Init,
  output logic               q_Play,
  output logic               q_Over
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int SUM_W = SCORE_W + 4;
  localparam logic [TIMER_W-1:0] DLY_MAX   = TIMER_W'(SPAWN_DELAY);
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [SUM_W-1:0]   SCORE_MAX = {4'b0, {SCORE_W{1'b1}}};

  state_t             state_q, state_d;
  logic [LANES-1:0]   full_q, full_d;
  logic [TIMER_W-1:0] delay_q [LANES];
  logic [TIMER_W-1:0] delay_d [LANES];
  logic [TIMER_W-1:0] occ_q   [LANES];
  logic [TIMER_W-1:0] occ_d   [LANES];
  logic [SCORE_W-1:0] score_q, score_d;

  logic               timeout;
  logic               clear_lanes;
  logic [LANES-1:0]   accepted, eligible, spawn;
  logic [3:0]         kill_cnt;
  logic [SUM_W-1:0]   score_sum;

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    score_d     = score_q;
    timeout     = 1'b0;
    clear_lanes = 1'b0;
    accepted    = '0;
    eligible    = '0;
    spawn       = '0;
    kill_cnt    = '0;
    score_sum   = '0;
    for (int i = 0; i < LANES; i++) begin
      delay_d[i] = delay_q[i];
      occ_d[i]   = occ_q[i];
    end

    case (state_q)
      S_INIT: begin
        clear_lanes = 1'b1;
        if (play_flag) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        accepted = full_q & kill;
        for (int i = 0; i < LANES; i++) begin
          if (full_q[i] && !kill[i] && occ_q[i] == TMO_LAST) timeout = 1'b1;
          eligible[i] = !full_q[i] && delay_q[i] == DLY_MAX && random[i];
        end
`ifdef NEXYS_SS_ONE_SPAWN_EN
        spawn = eligible & (~eligible + LANES'(1));
`else
        spawn = eligible;
`endif
        // A timeout freezes the field; only kills landing on this edge still count.
        if (timeout) begin
          spawn   = '0;
          state_d = S_OVER;
        end
        for (int i = 0; i < LANES; i++) begin
          if (accepted[i]) begin
            full_d[i]  = 1'b0;
            delay_d[i] = '0;
            occ_d[i]   = '0;
          end else if (!timeout) begin
            if (full_q[i]) begin
              occ_d[i] = occ_q[i] + 1'b1;
            end else if (spawn[i]) begin
              full_d[i] = 1'b1;
              occ_d[i]  = '0;
            end else if (delay_q[i] < DLY_MAX) begin
              delay_d[i] = delay_q[i] + 1'b1;
            end
          end
          kill_cnt = kill_cnt + {3'b0, accepted[i]};
        end
        score_sum = SUM_W'(score_q) + SUM_W'(kill_cnt);
        score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      end
      S_OVER: begin
        if (!play_flag) begin
          state_d     = S_INIT;
          clear_lanes = 1'b1;
        end
      end
      default: begin
        state_d     = S_INIT;
        clear_lanes = 1'b1;
      end
    endcase

    if (clear_lanes) begin
      full_d = '0;
      for (int i = 0; i < LANES; i++) begin
        delay_d[i] = '0;
        occ_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      full_q  <= '0;
      score_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        delay_q[i] <= '0;
        occ_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      score_q <= score_d;
      for (int i = 0; i < LANES; i++) begin
        delay_q[i] <= delay_d[i];
        occ_q[i]   <= occ_d[i];
      end
    end
  end

  assign monster  = full_q;
  assign score    = score_q;
  assign gameover = (state_q == S_OVER);
  assign q_Init   = (state_q == S_INIT);
  assign q_Play   = (state_q == S_PLAY);
  assign q_Over   = (state_q == S_OVER);

endmodule

// File: tb/tb_nexys_starship_lanes.sv
// Scoreboard bench for nexys_starship_lanes: stimulus queues expected outputs per edge, a negedge monitor compares.
module tb_nexys_starship_lanes;

  localparam logic [2:0] ST_INIT = 3'b100;
  localparam logic [2:0] ST_PLAY = 3'b010;
  localparam logic [2:0] ST_OVER = 3'b001;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] mon;
    logic       go;
    logic [7:0] sc;
    logic [2:0] st;
  } exp_t;

  logic       timer_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       play_flag = 1'b0;
  logic [3:0] random    = '0;
  logic [3:0] kill      = '0;
  logic [3:0] monster;
  logic       gameover;
  logic [7:0] score;
  logic       q_Init, q_Play, q_Over;

  logic       play2   = 1'b0;
  logic [3:0] random2 = '0;
  logic [3:0] kill2   = '0;
  logic [3:0] monster2;
  logic       gameover2;
  logic [1:0] score2;
  logic       q_Init2, q_Play2, q_Over2;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q2[$];

  nexys_starship_lanes dut (
    .timer_clk(timer_clk), .Reset(Reset), .play_flag(play_flag),
    .random(random), .kill(kill), .monster(monster), .gameover(gameover),
    .score(score), .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
  );

  nexys_starship_lanes #(.SCORE_W(2)) dut_sat (
    .timer_clk(timer_clk), .Reset(Reset), .play_flag(play2),
    .random(random2), .kill(kill2), .monster(monster2), .gameover(gameover2),
    .score(score2), .q_Init(q_Init2), .q_Play(q_Play2), .q_Over(q_Over2)
  );

  always #5 timer_clk = ~timer_clk;

  always @(posedge timer_clk) if (!Reset) cyc <= cyc + 1;

  task automatic chk(input exp_t e, input logic [3:0] m, input logic g,
                     input logic [7:0] s, input logic [2:0] st);
    total++;
    if (m !== e.mon || g !== e.go || s !== e.sc || st !== e.st) begin
      bad++;
      $display("FAIL %s cyc=%0d got mon=%b go=%b score=%0d st=%b want mon=%b go=%b score=%0d st=%b",
               e.nm, cyc, m, g, s, st, e.mon, e.go, e.sc, e.st);
    end
  endtask

  task automatic ex1(input int c, input string nm, input logic [3:0] m, input logic g,
                     input logic [7:0] s, input logic [2:0] st);
    q1.push_back('{c, nm, m, g, s, st});
  endtask

  task automatic ex2(input int c, input string nm, input logic [3:0] m, input logic [7:0] s);
    q2.push_back('{c, nm, m, 1'b0, s, ST_PLAY});
  endtask

  task automatic to_neg(input int c);
    while (cyc != c) @(negedge timer_clk);
  endtask

  // Monitor: pops every expectation due at this edge; anything older was skipped.
  always @(negedge timer_clk) begin
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      exp_t e;
      e = q1.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s missed at cyc=%0d (due %0d)", e.nm, cyc, e.cyc);
      end else begin
        chk(e, monster, gameover, score, {q_Init, q_Play, q_Over});
      end
    end
    while (q2.size() > 0 && q2[0].cyc <= cyc) begin
      exp_t e;
      e = q2.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s missed at cyc=%0d (due %0d)", e.nm, cyc, e.cyc);
      end else begin
        chk(e, monster2, gameover2, {6'b0, score2}, {q_Init2, q_Play2, q_Over2});
      end
    end
  end

  // Saturating-score instance: lane 0 spawns every 4 edges and is shot immediately.
  initial begin
    @(negedge Reset);
    play2   = 1'b1;
    random2 = 4'b0001;
    ex2(4, "t5_spawn", 4'b0001, 8'd0);
    for (int j = 0; j < 5; j++) begin
      to_neg(4 + 4 * j);
      kill2 = 4'b0001;
      ex2(5 + 4 * j, "t5_kill", 4'b0000, (j + 1 > 3) ? 8'd3 : 8'(j + 1));
      to_neg(5 + 4 * j);
      kill2 = 4'b0000;
      if (j < 4) ex2(8 + 4 * j, "t5_respawn", 4'b0001, (j + 1 > 3) ? 8'd3 : 8'(j + 1));
    end
    random2 = 4'b0000;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    repeat (2) @(negedge timer_clk);
    r = '{0, "reset", 4'b0000, 1'b0, 8'd0, ST_INIT};
    chk(r, monster, gameover, score, {q_Init, q_Play, q_Over});
    Reset = 1'b0;

    play_flag = 1'b1;
    random    = 4'b0001;
    ex1(1, "t1_play",  4'b0000, 1'b0, 8'd0, ST_PLAY);
    ex1(3, "t1_wait",  4'b0000, 1'b0, 8'd0, ST_PLAY);
    ex1(4, "t1_spawn", 4'b0001, 1'b0, 8'd0, ST_PLAY);

    to_neg(6);  kill = 4'b0001;
    ex1(7, "t2_kill", 4'b0000, 1'b0, 8'd1, ST_PLAY);
    to_neg(7);  kill = 4'b0010;
    ex1(8, "t2_kill_empty", 4'b0000, 1'b0, 8'd1, ST_PLAY);
    to_neg(8);  kill = 4'b0000;
    ex1(9,  "t2_wait",    4'b0000, 1'b0, 8'd1, ST_PLAY);
    ex1(10, "t2_respawn", 4'b0001, 1'b0, 8'd1, ST_PLAY);
    to_neg(10); kill = 4'b0001;
    ex1(11, "t2_kill2", 4'b0000, 1'b0, 8'd2, ST_PLAY);
    to_neg(11); kill = 4'b0000; random = 4'b0100;
    ex1(12, "t3_spawn", 4'b0100, 1'b0, 8'd2, ST_PLAY);
    to_neg(12); random = 4'b0000;
    ex1(17, "t3_pre",  4'b0100, 1'b0, 8'd2, ST_PLAY);
    ex1(18, "t3_over", 4'b0100, 1'b1, 8'd2, ST_OVER);
    to_neg(18); kill = 4'b0100;
    ex1(19, "t3_kill_over", 4'b0100, 1'b1, 8'd2, ST_OVER);
    to_neg(19); kill = 4'b0000; play_flag = 1'b0;
    ex1(20, "t3_init", 4'b0000, 1'b0, 8'd2, ST_INIT);

    to_neg(20); play_flag = 1'b1; random = 4'b1011;
    ex1(21, "t4_play",  4'b0000, 1'b0, 8'd0, ST_PLAY);
    ex1(24, "t4_spawn", 4'b1011, 1'b0, 8'd0, ST_PLAY);
    to_neg(24); random = 4'b0000;
    ex1(29, "t4_pre", 4'b1011, 1'b0, 8'd0, ST_PLAY);
    to_neg(29); kill = 4'b1011;
    ex1(30, "t4_kill", 4'b0000, 1'b0, 8'd3, ST_PLAY);
    to_neg(30); kill = 4'b0000;
    ex1(31, "t4_after", 4'b0000, 1'b0, 8'd3, ST_PLAY);

    to_neg(32); random = 4'b1111;
`ifdef NEXYS_SS_ONE_SPAWN_EN
    ex1(33, "t6_spawn_a", 4'b0001, 1'b0, 8'd3, ST_PLAY);
    ex1(34, "t6_spawn_b", 4'b0011, 1'b0, 8'd3, ST_PLAY);
    ex1(35, "t6_spawn_c", 4'b0111, 1'b0, 8'd3, ST_PLAY);
`else
    ex1(33, "t6_spawn_a", 4'b1111, 1'b0, 8'd3, ST_PLAY);
    ex1(34, "t6_spawn_b", 4'b1111, 1'b0, 8'd3, ST_PLAY);
    ex1(35, "t6_spawn_c", 4'b1111, 1'b0, 8'd3, ST_PLAY);
`endif
    ex1(36, "t6_spawn_d", 4'b1111, 1'b0, 8'd3, ST_PLAY);
    to_neg(36); random = 4'b0000;

    #3 Reset = 1'b1;
    #1;
    r = '{cyc, "t7_async_reset", 4'b0000, 1'b0, 8'd0, ST_INIT};
    chk(r, monster, gameover, score, {q_Init, q_Play, q_Over});
    @(negedge timer_clk);
    Reset = 1'b0;
    repeat (2) @(negedge timer_clk);

    if (q1.size() != 0 || q2.size() != 0) begin
      total++; bad++;
      $display("FAIL pending_expectations got q1=%0d q2=%0d want 0", q1.size(), q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
